// File: rtl/io_feeder_fifo.sv
// Burst-oriented IO feeder: buffers host words in a circular FIFO and hands a
// BURST-word block to the CPU data bus, one word per cycle while ld is held.
module io_feeder_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int BURST  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     intrpt,
    input  logic                     ld,
    output logic [DATA_W-1:0]        dataBus,
    output logic                     valid,
    output logic                     last
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, ARMED, XFER} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d, beat_q, beat_d;
    logic                ovf_q, ovf_d, valid_q, valid_d, last_q, last_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                pop, push;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign overflow = ovf_q;
    assign intrpt   = (state_q == ARMED);
    assign dataBus  = data_q;
    assign valid    = valid_q;
    assign last     = last_q;

    assign pop  = ld && ((state_q == ARMED) || (state_q == XFER));
    assign push = wr_en && (!full || pop);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (wr_en && full && !pop) ovf_d = 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (count_q >= CNT_W'(BURST)) state_d = ARMED;
            end
            ARMED, XFER: begin
                if (pop) begin
                    data_d   = mem[rd_ptr_q];
                    valid_d  = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (beat_q == CNT_W'(BURST - 1)) begin
                        last_d  = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                        state_d = XFER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // flush discards everything, including a burst in progress
        if (flush) begin
            state_d  = IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            beat_d   = '0;
            ovf_d    = 1'b0;
            data_d   = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset; a slot written at full while popping is read
    // before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wr_data;
    end
endmodule
